// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and state encoding for the seven-segment serial transmitter
package seg_pkg;
  localparam int SEG_WIDTH = 64;
  localparam int SEG_DIV = 2;
  localparam int SEG_BITS_W = 7;
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} seg_state_t;
endpackage

// File: rtl/seg_txt_shifter_tick_gen.sv
// seg_tick_gen: DIV-cycle phase counter; tick is high in the last cycle of each phase, restart re-arms it at phase entry
module seg_tick_gen
  import seg_pkg::*;
#(
  parameter int DIV = SEG_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= restart ? '0 : cnt + CW'(1);
  assign tick = cnt == CW'(DIV - 1);
endmodule

// File: rtl/seg_txt_shifter.sv
// seg_txt_shifter: shifts a 64-bit segment image MSB-first into the display's serial register chain, then pulses the latch
module seg_txt_shifter
  import seg_pkg::*;
#(
  parameter int DIV = SEG_DIV,
  parameter int WIDTH = SEG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seg_txt,
  output logic             seg_clk,
  output logic             seg_sout,
  output logic             seg_clrn,
  output logic             seg_pen,
  output logic             busy,
  output logic             done
);
  seg_state_t state;
  logic [WIDTH-1:0] sr;
  logic [SEG_BITS_W-1:0] bits;
  logic tick;
  logic restart;
  assign restart = state == IDLE || state == DONE || tick;
  seg_tick_gen #(.DIV(DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .restart(restart),
    .tick(tick)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      bits <= '0;
      seg_clk <= 1'b0;
      seg_sout <= 1'b0;
      seg_clrn <= 1'b0;
      seg_pen <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      seg_clrn <= 1'b1;
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sr <= seg_txt;
            bits <= SEG_BITS_W'(WIDTH);
            seg_sout <= seg_txt[WIDTH-1];
            busy <= 1'b1;
            state <= SHIFT_LO;
          end else state <= IDLE;
        end
        SHIFT_LO: if (tick) begin
          seg_clk <= 1'b1;
          state <= SHIFT_HI;
        end
        SHIFT_HI: if (tick) begin
          seg_clk <= 1'b0;
          bits <= bits - SEG_BITS_W'(1);
          if (bits != SEG_BITS_W'(1)) begin
            sr <= sr << 1;
            seg_sout <= sr[WIDTH-2];
            state <= SHIFT_LO;
          end else begin
            seg_pen <= 1'b1;
            state <= LATCH;
          end
        end
        LATCH: if (tick) begin
          seg_pen <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_seg_txt_shifter.sv
// tb_seg_txt_shifter: directed checks of serial stream, latch pulse and frame timing for DIV=2 and DIV=1
module tb_seg_txt_shifter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_i [2];
  logic [63:0] txt_i [2];
  logic sclk [2];
  logic sout [2];
  logic clrn [2];
  logic pen [2];
  logic busy_o [2];
  logic done_o [2];
  int total = 0;
  int bad = 0;
  logic [63:0] stream [2] = '{default: '0};
  int rises [2] = '{default: 0};
  int pens [2] = '{default: 0};
  int dones [2] = '{default: 0};
  logic prev_clk [2] = '{default: 1'b0};
  always #5 clk = ~clk;
  seg_txt_shifter #(.DIV(2)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .seg_txt(txt_i[0]),
    .seg_clk(sclk[0]), .seg_sout(sout[0]), .seg_clrn(clrn[0]),
    .seg_pen(pen[0]), .busy(busy_o[0]), .done(done_o[0])
  );
  seg_txt_shifter #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .seg_txt(txt_i[1]),
    .seg_clk(sclk[1]), .seg_sout(sout[1]), .seg_clrn(clrn[1]),
    .seg_pen(pen[1]), .busy(busy_o[1]), .done(done_o[1])
  );
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (sclk[i] && !prev_clk[i]) begin
        stream[i] <= {stream[i][62:0], sout[i]};
        rises[i] <= rises[i] + 1;
      end
      if (pen[i]) pens[i] <= pens[i] + 1;
      if (done_o[i]) dones[i] <= dones[i] + 1;
      prev_clk[i] <= sclk[i];
    end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic frame(input int sel, input logic [63:0] txt, input bit disturb,
                       input logic [63:0] exp_s, input int exp_edge, input int exp_pen);
    int r0, d0, p0, n;
    bit busy_ok;
    r0 = rises[sel];
    d0 = dones[sel];
    p0 = pens[sel];
    @(negedge clk);
    txt_i[sel] = txt;
    start_i[sel] = 1'b1;
    @(negedge clk);
    start_i[sel] = 1'b0;
    if (disturb) txt_i[sel] = '1;
    n = 0;
    busy_ok = 1'b1;
    while (!done_o[sel] && n < 600) begin
      if (!busy_o[sel]) busy_ok = 1'b0;
      start_i[sel] = disturb && (n == 20 || n == 100);
      @(negedge clk);
      n++;
    end
    start_i[sel] = 1'b0;
    check("done_edge", 64'(n), 64'(exp_edge));
    check("busy_in_frame", 64'(busy_ok), 64'd1);
    check("busy_at_done", 64'(busy_o[sel]), 64'd0);
    @(negedge clk);
    check("done_width", 64'(done_o[sel]), 64'd0);
    repeat (3) @(negedge clk);
    check("stream", stream[sel], exp_s);
    check("rises", 64'(rises[sel] - r0), 64'd64);
    check("pen_cycles", 64'(pens[sel] - p0), 64'(exp_pen));
    check("done_count", 64'(dones[sel] - d0), 64'd1);
  endtask
  typedef struct {
    int sel;
    logic [63:0] txt;
    bit disturb;
    logic [63:0] exp_s;
    int exp_edge;
    int exp_pen;
  } vec_t;
  vec_t vecs [6];
  initial begin
    int n, k, lows, d0, r0;
    int t [3];
    vecs[0] = '{0, 64'h8000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0001, 258, 2};
    vecs[1] = '{0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 258, 2};
    vecs[2] = '{0, 64'h8000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0001, 258, 2};
    vecs[3] = '{0, 64'h0000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_0000, 258, 2};
    vecs[4] = '{1, 64'h8000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0001, 129, 1};
    vecs[5] = '{1, 64'hC3C3_0F0F_1234_5678, 1'b0, 64'hC3C3_0F0F_1234_5678, 129, 1};
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0;
      txt_i[i] = '0;
    end
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", 64'({sclk[0], sout[0], clrn[0], pen[0], busy_o[0], done_o[0]}), 64'd0);
    check("reset_outputs_div1", 64'({sclk[1], sout[1], clrn[1], pen[1], busy_o[1], done_o[1]}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("clrn_after_release", 64'({sclk[0], sout[0], clrn[0], pen[0], busy_o[0], done_o[0]}), 64'b001000);
    for (int i = 0; i < 6; i++)
      frame(vecs[i].sel, vecs[i].txt, vecs[i].disturb, vecs[i].exp_s, vecs[i].exp_edge, vecs[i].exp_pen);
    d0 = dones[0];
    @(negedge clk);
    txt_i[0] = 64'hA5A5_A5A5_A5A5_A5A5;
    start_i[0] = 1'b1;
    n = 0;
    k = 0;
    lows = 0;
    t = '{0, 0, 0};
    while (k < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (!busy_o[0]) lows++;
      if (done_o[0]) begin
        t[k] = n;
        k++;
      end
    end
    start_i[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("refresh_frames", 64'(k), 64'd3);
    check("refresh_period1", 64'(t[1] - t[0]), 64'd259);
    check("refresh_period2", 64'(t[2] - t[1]), 64'd259);
    check("refresh_busy_low", 64'(lows), 64'd3);
    check("refresh_done_count", 64'(dones[0] - d0), 64'd3);
    check("refresh_stream", stream[0], 64'hA5A5_A5A5_A5A5_A5A5);
    r0 = rises[0];
    d0 = dones[0];
    @(negedge clk);
    txt_i[0] = 64'hFFFF_0000_FFFF_0000;
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    n = 0;
    while (rises[0] - r0 < 30 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached", 64'(rises[0] - r0 >= 30), 64'd1);
    #3 rst = 1'b1;
    #1;
    check("abort_outputs", 64'({sclk[0], sout[0], clrn[0], pen[0], busy_o[0], done_o[0]}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(dones[0] - d0), 64'd0);
    check("abort_idle", 64'({clrn[0], busy_o[0]}), 64'b10);
    frame(0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 258, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg_txt_shifter.md
# seg_txt_shifter

Serial transmitter for the board's eight-digit seven-segment display. It takes the 64-bit segment image produced by the hex-to-segment encoder (8 digits × 8 active-low segment bits) and shifts it MSB-first into the display's external serial-in/parallel-out register chain. When all 64 bits are in, it pulses the latch enable. It sits between the display encoder and the top-level seg_* pins.

## Interface
Parameters:
- DIV, 2: system clocks per seg_clk half-period; must be ≥ 1.
- WIDTH, 64: frame length in bits; fixed to SEG_WIDTH from the package.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only when busy = 0.
- seg_txt  in  WIDTH  segment image; bit 63 is shifted first; captured on the accepting edge.
- seg_clk  out  1  serial shift clock to the display chain.
- seg_sout  out  1  serial data; stable across each seg_clk rising edge.
- seg_clrn  out  1  active-low clear to the display chain.
- seg_pen  out  1  parallel latch enable, active-high.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the frame completes.

## Operation
- All outputs are registered. Reset values: seg_clk = 0, seg_sout = 0, seg_clrn = 0, seg_pen = 0, busy = 0, done = 0.
- seg_clrn goes to 1 on the first clk edge after rst deasserts and stays 1.
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE
  - If start = 1, load seg_txt into a 64-bit shift register and set the bit counter to WIDTH.
  - Drive seg_sout = seg_txt[63], set busy = 1, go to SHIFT_LO.
  - If start = 0, outputs hold.
- SHIFT_LO: seg_clk = 0 for DIV cycles, then go to SHIFT_HI.
- SHIFT_HI
  - seg_clk = 1 for DIV cycles; the display samples seg_sout on the rising edge.
  - At the end of the phase, decrement the counter.
  - If the counter is nonzero, shift left, put the new MSB on seg_sout, and go to SHIFT_LO.
  - If the counter is zero, go to LATCH.
- LATCH: seg_clk = 0 and seg_pen = 1 for DIV cycles, then go to DONE.
- DONE: seg_pen = 0, busy = 0, done = 1 for exactly one cycle, then go to IDLE.
  - start is sampled in DONE as if in IDLE, so start held high gives back-to-back frames.
- start while busy = 1 is ignored. Changes on seg_txt after capture have no effect on the frame in flight.
- Phase timing comes from a divider counter, 0..DIV-1, restarted on every phase entry.
- Bit counter width is 7 bits. It never wraps, since WIDTH ≤ 127.
- Async reset at any point aborts the frame immediately: every output takes its reset value, no done pulse, state returns to IDLE.

## Timing
- Take edge 0 as the edge that accepts start.
- busy = 1 from edge 0 through edge 2·WIDTH·DIV + DIV, i.e. 258 cycles for WIDTH = 64, DIV = 2.
- done = 1 in the following cycle, cycle 259 for DIV = 2. busy = 0 in that cycle.
- seg_sout changes only at SHIFT_LO entry. Setup and hold around each seg_clk rise are both DIV clk cycles.
- The 64th seg_clk rising edge is followed by DIV cycles of seg_clk = 0 before seg_pen rises.
- The frame period is 129·DIV + 1 cycles.

## Structure
- Shared package seg_pkg holds:
  - SEG_WIDTH = 64.
  - The state enum: IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE.
  - The default DIV constant, also used by the top-level clocking.
- One natural sub-module, seg_tick_gen: a DIV-cycle phase counter with a synchronous restart input and a one-cycle tick output. The FSM, shift register and bit counter stay in seg_txt_shifter.

## Test plan
- Reset: assert rst mid-cycle → all outputs take reset values without waiting for clk; seg_clrn = 1 one edge after release.
- Single frame, DIV = 2, seg_txt = 64'h8000_0000_0000_0001, one-cycle start → seg_sout sampled at the seg_clk rises reads 1, then 62 zeros, then 1. seg_pen is high for 2 cycles. done pulses at cycle 259.
- Capture isolation: after start, change seg_txt to 64'hFFFF_FFFF_FFFF_FFFF and pulse start again during busy → the serial stream still matches the original value, and there is exactly one done.
- Continuous refresh: hold start = 1 with seg_txt = 64'hA5A5_A5A5_A5A5_A5A5 → frames run back to back. busy is low only in the one DONE cycle per frame, and the stream repeats 1010_0101.
- Abort: assert rst after the 30th seg_clk rise → outputs reset immediately and there is no done. A subsequent start with 64'h0123_4567_89AB_CDEF shifts a complete, correct frame.
- DIV = 1 → each seg_clk phase lasts 1 cycle and done arrives at cycle 130.
